write_arbiter: RTL and testbench
================================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width of every stream port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets the block).
REQ-004 SHALL have ports input_a, input_b, input_c  input  WIDTH  requester data words.
REQ-005 SHALL have ports input_a_stb, input_b_stb, input_c_stb  input  1  requester word valid.
REQ-006 SHALL have ports input_a_ack, input_b_ack, input_c_ack  output  1  requester word accepted.
REQ-007 SHALL have port output_z  output  WIDTH  forwarded word to the single shared sink (file writer).
REQ-008 SHALL have port output_z_stb  output  1  forwarded word valid.
REQ-009 SHALL have port output_z_ack  input  1  sink accepts word.
REQ-010 SHALL have port word_count  output  32  total words delivered to the sink.

Function
REQ-011 SHALL transfer a word on any stb/ack pair only at a rising edge where both are 1; producer holds data and stb until that edge.
REQ-012 SHALL implement states IDLE, ACCEPT, SEND.
REQ-013 IDLE: if any input stb==1, SHALL grant one requester and enter ACCEPT with that requester's ack=1 from the next cycle; else stay IDLE.
REQ-014 Grant SHALL be round-robin: search order starts at the index after the last completed grant (a=0, b=1, c=2, wrapping c->a).
REQ-015 At most one input ack SHALL be 1 in any cycle; non-granted acks stay 0.
REQ-016 ACCEPT: on transfer, SHALL latch the word into a WIDTH-bit buffer, drop ack next cycle, enter SEND.
REQ-017 ACCEPT: if the granted stb falls without a transfer, SHALL hold ack and remain in ACCEPT (no timeout, no regrant).
REQ-018 SEND: output_z SHALL equal the buffer and output_z_stb=1, both stable until output_z_ack==1 at an edge.
REQ-019 SEND: on sink transfer, SHALL drop output_z_stb next cycle, advance the round-robin pointer past the granted index, increment word_count, return to IDLE.
REQ-020 Latency: stb seen in IDLE at edge N -> ack high cycle N+1; with input stb held and sink ack constantly 1, output_z_stb high from cycle N+2, word delivered at edge N+2; next grant sampled at edge N+3.
REQ-021 word_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-022 output_z SHALL hold its last value outside SEND; output_z_stb SHALL be 0 outside SEND.
REQ-023 Requester stb changes on non-granted inputs SHALL not affect the current grant.

Reset
REQ-024 On rst==0: state=IDLE, all input acks=0, output_z_stb=0, output_z=0, word_count=0, round-robin pointer=a (a highest priority).
REQ-025 Reset mid-ACCEPT or mid-SEND SHALL discard the buffered word without delivery or count increment.
REQ-026 Reset SHALL take priority over every other update in the same cycle.

Structure
REQ-027 Shared package SHALL hold state type (IDLE/ACCEPT/SEND), NUM_INPUTS=3, and requester index constants A=0, B=1, C=2.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_select (inputs: 3-bit request, 2-bit pointer; outputs: grant valid, 2-bit index).
REQ-029 All outputs SHALL be driven from registers.

Verification
REQ-030 Single source: input_b=32'h3F800000 stb held, sink ack=1 -> input_b_ack high 1 cycle, output_z=32'h3F800000 with stb for exactly 1 cycle, word_count=1.
REQ-031 Contention: a, b, c stb together from reset with values 1, 2, 3, held after each ack then new words -> sink order a,b,c,a,b,c; never two acks high.
REQ-032 Sink backpressure: output_z_ack=0 for 10 cycles in SEND -> output_z and stb stable 10 cycles, no input ack, count unchanged; ack=1 -> delivered once.
REQ-033 Reset mid-SEND: rst=0 during SEND with 32'hDEADBEEF buffered -> no delivery, all stb/ack 0, word_count=0, next grant favours a.
REQ-034 Counter wrap: preload via 2^32-1 deliveries (forced start value) -> next delivery shows word_count=0.
REQ-035 Stb withdrawal: granted input_c drops stb before ack edge -> input_c_ack stays 1, state ACCEPT, no output_z_stb.

Source files
------------

// File: rtl/write_arbiter_pkg.sv
// Shared types and constants for the three-input write arbiter.
// Holds the FSM state type, requester indices and the round-robin wrap helper.
package write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam int NUM_INPUTS = 3;

    localparam logic [1:0] A = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] C = 2'd2;

    // Requester index that follows idx in round-robin order (c wraps to a).
    function automatic logic [1:0] next_index(input logic [1:0] idx);
        return (idx >= C) ? A : idx + 2'd1;
    endfunction

endpackage

// File: rtl/write_arbiter_rr_select.sv
// Combinational round-robin picker: first active request at or after pointer.
// An out-of-range pointer is treated as a, so the search always starts somewhere legal.
module rr_select
    import write_arbiter_pkg::*;
(
    input  logic [NUM_INPUTS-1:0] request,
    input  logic [1:0]            pointer,
    output logic                  grant_valid,
    output logic [1:0]            grant_index
);

    logic [1:0] candidate;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = A;
        candidate   = (pointer > C) ? A : pointer;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!grant_valid && request[candidate]) begin
                grant_valid = 1'b1;
                grant_index = candidate;
            end
            candidate = next_index(candidate);
        end
    end

endmodule

// File: rtl/write_arbiter.sv
// Round-robin arbiter funnelling three stb/ack word streams into one sink.
// One word is in flight at a time: IDLE grants, ACCEPT captures, SEND delivers.
module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic             input_a_stb,
    input  logic             input_b_stb,
    input  logic             input_c_stb,
    output logic             input_a_ack,
    output logic             input_b_ack,
    output logic             input_c_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic [31:0]      word_count
);

    state_t                state, state_next;
    logic [1:0]            grant_idx, grant_idx_next;
    logic [1:0]            pointer, pointer_next;
    logic [NUM_INPUTS-1:0] ack_q, ack_next;
    logic [WIDTH-1:0]      z_next;
    logic                  z_stb_next;
    logic                  deliver;
    logic [31:0]           count_next;

    logic [NUM_INPUTS-1:0] request;
    logic                  sel_valid;
    logic [1:0]            sel_index;
    logic [WIDTH-1:0]      granted_word;

    assign request = {input_c_stb, input_b_stb, input_a_stb};

    rr_select u_rr_select (
        .request     (request),
        .pointer     (pointer),
        .grant_valid (sel_valid),
        .grant_index (sel_index)
    );

    always_comb begin
        case (grant_idx)
            A:       granted_word = input_a;
            B:       granted_word = input_b;
            default: granted_word = input_c;
        endcase
    end

    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        pointer_next   = pointer;
        ack_next       = ack_q;
        z_next         = output_z;
        z_stb_next     = output_z_stb;
        deliver        = 1'b0;

        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant_idx_next = sel_index;
                    ack_next       = 3'b001 << sel_index;
                    state_next     = ACCEPT;
                end
            end
            ACCEPT: begin
                // Ack stays high through ACCEPT, so the granted stb alone marks the transfer.
                if (request[grant_idx]) begin
                    z_next     = granted_word;
                    z_stb_next = 1'b1;
                    ack_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (output_z_ack) begin
                    z_stb_next   = 1'b0;
                    pointer_next = next_index(grant_idx);
                    deliver      = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                ack_next   = '0;
                z_stb_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Written every cycle so the counter always reflects its own current value plus one delivery.
    assign count_next = word_count + 32'(deliver);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the word buffer doubles as output_z, which must read 0 after reset, so it is reset too.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_idx    <= A;
            pointer      <= A;
            ack_q        <= '0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
            word_count   <= '0;
        end else begin
            grant_idx    <= grant_idx_next;
            pointer      <= pointer_next;
            ack_q        <= ack_next;
            output_z     <= z_next;
            output_z_stb <= z_stb_next;
            word_count   <= count_next;
        end
    end

    assign input_a_ack = ack_q[A];
    assign input_b_ack = ack_q[B];
    assign input_c_ack = ack_q[C];

endmodule

// File: tb/tb_write_arbiter.sv
// Directed bench for write_arbiter: producers driven from per-input queues,
// delivered words checked in order against a scoreboard queue.
module tb_write_arbiter;
    import write_arbiter_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data [3];
    logic [2:0]       in_stb;
    logic [2:0]       in_ack;
    logic [WIDTH-1:0] z;
    logic             z_stb;
    logic             sink_ack;
    logic [31:0]      word_count;

    logic [WIDTH-1:0] pend [3][$];
    logic [WIDTH-1:0] exp_q [$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               delivered = 0;

    always #5 clk = ~clk;

    write_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (in_data[0]),
        .input_b      (in_data[1]),
        .input_c      (in_data[2]),
        .input_a_stb  (in_stb[0]),
        .input_b_stb  (in_stb[1]),
        .input_c_stb  (in_stb[2]),
        .input_a_ack  (in_ack[0]),
        .input_b_ack  (in_ack[1]),
        .input_c_ack  (in_ack[2]),
        .output_z     (z),
        .output_z_stb (z_stb),
        .output_z_ack (sink_ack),
        .word_count   (word_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sink side: ack-one-hot every cycle, and each word the sink takes is popped and compared.
    always @(negedge clk) begin
        if (rst) begin
            check("one_hot_ack", ($countones(in_ack) <= 1), 1);
            if (z_stb && sink_ack) begin
                if (exp_q.size() == 0) check("unexpected_delivery", 1, 0);
                else check("delivered_word", z, exp_q.pop_front());
                delivered++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            in_stb[i] = (pend[i].size() != 0);
            if (pend[i].size() != 0) in_data[i] = pend[i][0];
        end
    endtask

    // One clock of queue-driven producers: a word leaves its queue once stb and ack met at the edge.
    task automatic step();
        logic [2:0] fire;
        fire = in_stb & in_ack;
        tick();
        for (int i = 0; i < 3; i++)
            if (fire[i]) void'(pend[i].pop_front());
        drive_inputs();
    endtask

    task automatic wait_delivered(input int target, input int budget);
        int k = 0;
        while (delivered < target && k < budget) begin
            step();
            k++;
        end
        check("delivery_timeout", (delivered >= target), 1);
    endtask

    task automatic wait_send(input int budget);
        int k = 0;
        while (!z_stb && k < budget) begin
            step();
            k++;
        end
        check("send_timeout", z_stb, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pend[i].delete();
        drive_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int target;
        in_stb   = '0;
        sink_ack = 1'b1;
        for (int i = 0; i < 3; i++) in_data[i] = '0;

        // Reset state
        do_reset();
        check("rst_acks", in_ack, 3'b000);
        check("rst_z_stb", z_stb, 0);
        check("rst_z", z, 0);
        check("rst_count", word_count, 0);

        // Single source on b, cycle by cycle
        exp_q.push_back(32'h3F80_0000);
        in_data[1] = 32'h3F80_0000;
        in_stb[1]  = 1'b1;
        tick();
        check("single_ack_rises", in_ack, 3'b010);
        check("single_no_stb_yet", z_stb, 0);
        tick();
        check("single_ack_drops", in_ack, 3'b000);
        check("single_z_stb", z_stb, 1);
        check("single_z", z, 32'h3F80_0000);
        in_stb[1] = 1'b0;
        tick();
        check("single_stb_one_cycle", z_stb, 0);
        check("single_count", word_count, 1);
        tick();
        check("single_no_regrant", in_ack, 3'b000);

        // Three-way contention from reset: order a,b,c,a,b,c
        do_reset();
        pend[0].push_back(32'd1); pend[0].push_back(32'd4);
        pend[1].push_back(32'd2); pend[1].push_back(32'd5);
        pend[2].push_back(32'd3); pend[2].push_back(32'd6);
        for (int w = 1; w <= 6; w++) exp_q.push_back(WIDTH'(w));
        drive_inputs();
        target = delivered + 6;
        wait_delivered(target, 60);
        check("contention_count", word_count, 6);

        // Sink backpressure for 10 cycles, c requesting meanwhile
        sink_ack = 1'b0;
        pend[0].push_back(32'hA5A5_0001);
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'h0C0C_0C0C);
        target = delivered + 2;
        drive_inputs();
        wait_send(10);
        pend[2].push_back(32'h0C0C_0C0C);
        drive_inputs();
        for (int k = 0; k < 10; k++) begin
            check("bp_z_stable", z, 32'hA5A5_0001);
            check("bp_stb_held", z_stb, 1);
            check("bp_no_ack", in_ack, 3'b000);
            check("bp_count_held", word_count, 6);
            step();
        end
        sink_ack = 1'b1;
        step();
        check("bp_released_stb", z_stb, 0);
        check("bp_released_count", word_count, 7);
        wait_delivered(target, 20);
        check("bp_second_count", word_count, 8);

        // Reset while DEADBEEF waits in SEND
        sink_ack = 1'b0;
        pend[1].push_back(32'hDEAD_BEEF);
        drive_inputs();
        wait_send(10);
        check("mid_send_buffered", z, 32'hDEAD_BEEF);
        do_reset();
        check("mid_send_z_stb", z_stb, 0);
        check("mid_send_acks", in_ack, 3'b000);
        check("mid_send_count", word_count, 0);
        check("mid_send_z", z, 0);
        sink_ack = 1'b1;
        pend[1].push_back(32'h22);
        pend[0].push_back(32'h11);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        drive_inputs();
        target = delivered + 2;
        wait_delivered(target, 20);
        check("post_reset_count", word_count, 2);

        // Granted c withdraws stb; a requesting must not steal the grant
        in_data[2] = 32'h77;
        in_stb[2]  = 1'b1;
        tick();
        check("withdraw_granted", in_ack, 3'b100);
        in_stb[2]  = 1'b0;
        in_data[0] = 32'h88;
        in_stb[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("withdraw_ack_held", in_ack, 3'b100);
            check("withdraw_no_z_stb", z_stb, 0);
            check("withdraw_state", dut.state, ACCEPT);
        end
        pend[2].push_back(32'h77);
        pend[0].push_back(32'h88);
        exp_q.push_back(32'h77);
        exp_q.push_back(32'h88);
        drive_inputs();
        target = delivered + 2;
        wait_delivered(target, 20);
        check("withdraw_count", word_count, 4);

        // Counter wrap from a forced all-ones start value
        force dut.word_count = 32'hFFFF_FFFF;
        tick();
        release dut.word_count;
        check("wrap_preload", word_count, 32'hFFFF_FFFF);
        pend[0].push_back(32'h5);
        exp_q.push_back(32'h5);
        drive_inputs();
        target = delivered + 1;
        wait_delivered(target, 20);
        check("wrap_to_zero", word_count, 0);

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
